// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard consumer: turns load-use/branch/jump/memory-busy requests into
// register write enables, flushes and PC enable, with stale-request masking and perf counters.
module hazard_stall_ctrl #(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Load_Use,
    input  logic             Branch_Taken,
    input  logic             Jump,
    input  logic             Mem_Busy,
    input  logic             Cnt_Clr,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_Ex_Flush,
    output logic             Ex_Mem_Hold,
    output logic [1:0]       Ctrl_State,
    output logic [CNT_W-1:0] Stall_Cnt,
    output logic [CNT_W-1:0] Flush_Cnt,
    output logic             Mem_Timeout
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_BUBBLE = 2'd1,
        FLUSHED   = 2'd2,
        MEM_WAIT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg, wait_cnt_reg;
    logic             timeout_reg;
    logic             load_use_eff;

    // The cycle after a bubble or flush, ID/EX holds a bubble, so a load-use hit is stale.
    assign load_use_eff = Load_Use && (state_reg != LU_BUBBLE) && (state_reg != FLUSHED);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= RUN;
        else
            state_reg <= state_next;
    end

    // Next-state logic; MEM_WAIT needs no special case since exit re-evaluates normally
    always_comb begin
        state_next = RUN;
        if (Mem_Busy)
            state_next = MEM_WAIT;
        else if (Branch_Taken)
            state_next = FLUSHED;
        else if (load_use_eff)
            state_next = LU_BUBBLE;
        else if (Jump)
            state_next = FLUSHED;
    end

    // Output logic, forced low while reset is asserted
    always_comb begin
        PC_Write    = 1'b0;
        IF_ID_Write = 1'b0;
        IF_ID_Flush = 1'b0;
        ID_Ex_Flush = 1'b0;
        Ex_Mem_Hold = 1'b0;
        if (rst_n) begin
            if (Mem_Busy) begin
                Ex_Mem_Hold = 1'b1;
            end else if (Branch_Taken) begin
                PC_Write    = 1'b1;
                IF_ID_Write = 1'b1;
                IF_ID_Flush = 1'b1;
                ID_Ex_Flush = 1'b1;
            end else if (load_use_eff) begin
                ID_Ex_Flush = 1'b1;
            end else if (Jump) begin
                PC_Write    = 1'b1;
                IF_ID_Write = 1'b1;
                IF_ID_Flush = 1'b1;
            end else begin
                PC_Write    = 1'b1;
                IF_ID_Write = 1'b1;
            end
        end
    end

    // Saturating performance counters; clear beats increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else if (Cnt_Clr) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (!PC_Write && stall_cnt_reg != '1)
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            if (IF_ID_Flush && flush_cnt_reg != '1)
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
        end
    end

    // Memory-wait watchdog; the count parks at MAX_WAIT-1 so it can never wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else if (Mem_Busy) begin
            if (wait_cnt_reg == WAIT_LAST)
                timeout_reg <= 1'b1;
            else
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end else begin
            wait_cnt_reg <= '0;
        end
    end

    assign Ctrl_State  = state_reg;
    assign Stall_Cnt   = stall_cnt_reg;
    assign Flush_Cnt   = flush_cnt_reg;
    assign Mem_Timeout = timeout_reg;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a MAX_WAIT=4 instance for control/watchdog
// and a CNT_W=2 instance sharing the same inputs for counter saturation.
module tb_hazard_stall_ctrl;

    logic clk = 1'b0;
    logic rst_n, load_use, branch_taken, jump, mem_busy, cnt_clr;

    logic        pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_hold, mem_timeout;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_flush, s_ex_mem_hold, s_mem_timeout;
    logic [1:0]  s_ctrl_state;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.CNT_W(16), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .Load_Use(load_use), .Branch_Taken(branch_taken),
        .Jump(jump), .Mem_Busy(mem_busy), .Cnt_Clr(cnt_clr),
        .PC_Write(pc_write), .IF_ID_Write(if_id_write), .IF_ID_Flush(if_id_flush),
        .ID_Ex_Flush(id_ex_flush), .Ex_Mem_Hold(ex_mem_hold), .Ctrl_State(ctrl_state),
        .Stall_Cnt(stall_cnt), .Flush_Cnt(flush_cnt), .Mem_Timeout(mem_timeout)
    );

    hazard_stall_ctrl #(.CNT_W(2), .MAX_WAIT(3)) dut_s (
        .clk(clk), .rst_n(rst_n), .Load_Use(load_use), .Branch_Taken(branch_taken),
        .Jump(jump), .Mem_Busy(mem_busy), .Cnt_Clr(cnt_clr),
        .PC_Write(s_pc_write), .IF_ID_Write(s_if_id_write), .IF_ID_Flush(s_if_id_flush),
        .ID_Ex_Flush(s_id_ex_flush), .Ex_Mem_Hold(s_ex_mem_hold), .Ctrl_State(s_ctrl_state),
        .Stall_Cnt(s_stall_cnt), .Flush_Cnt(s_flush_cnt), .Mem_Timeout(s_mem_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic lu, input logic bt, input logic jp, input logic mb, input logic clr);
        load_use = lu; branch_taken = bt; jump = jp; mem_busy = mb; cnt_clr = clr;
    endtask

    // Check combinational controls mid-cycle: {PC_Write, IF_ID_Write, IF_ID_Flush, ID_Ex_Flush, Ex_Mem_Hold}
    task automatic chk_ctl(input string tag, input logic [4:0] exp);
        @(negedge clk);
        chk(tag, 32'({pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_hold}), 32'(exp));
        $display("%t %s ctl=%b", $time, tag, {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_hold});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        #12;
        chk("rst_ctl", 32'({pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_hold}), 32'd0);
        chk("rst_state", 32'(ctrl_state), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        chk("rst_flush", 32'(flush_cnt), 32'd0);
        chk("rst_tmo", 32'(mem_timeout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Idle run
        for (int i = 0; i < 5; i++) begin
            chk_ctl("idle_ctl", 5'b11000);
            tick();
        end
        chk("idle_state", 32'(ctrl_state), 32'd0);
        chk("idle_stall", 32'(stall_cnt), 32'd0);
        chk("idle_flush", 32'(flush_cnt), 32'd0);

        // Load-use held two cycles: stall once, then masked
        drive(1, 0, 0, 0, 0);
        chk_ctl("lu1_ctl", 5'b00010);
        tick();
        chk("lu1_state", 32'(ctrl_state), 32'd1);
        chk_ctl("lu2_masked", 5'b11000);
        tick();
        chk("lu2_state", 32'(ctrl_state), 32'd0);
        chk("lu_stall", 32'(stall_cnt), 32'd1);

        drive(0, 0, 0, 0, 1);
        tick();
        chk("clr_stall", 32'(stall_cnt), 32'd0);

        // Branch beats load-use, next-cycle load-use masked
        drive(1, 1, 0, 0, 0);
        chk_ctl("br_lu_ctl", 5'b11110);
        tick();
        chk("br_state", 32'(ctrl_state), 32'd2);
        drive(1, 0, 0, 0, 0);
        chk_ctl("br_lu_masked", 5'b11000);
        tick();
        chk("br_ret_state", 32'(ctrl_state), 32'd0);
        chk("br_flush", 32'(flush_cnt), 32'd1);
        chk("br_stall", 32'(stall_cnt), 32'd0);

        drive(0, 0, 0, 0, 1);
        tick();

        // Mem_Busy freeze with Jump held, jump honoured when unfrozen
        drive(0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            chk_ctl("mb_jump_ctl", 5'b00001);
            tick();
        end
        chk("mb_state", 32'(ctrl_state), 32'd3);
        drive(0, 0, 1, 0, 0);
        chk_ctl("mb_exit_jump", 5'b11100);
        tick();
        chk("mbj_state", 32'(ctrl_state), 32'd2);
        chk("mbj_stall", 32'(stall_cnt), 32'd3);
        chk("mbj_flush", 32'(flush_cnt), 32'd1);
        chk("mbj_tmo", 32'(mem_timeout), 32'd0);

        // Load-use is not masked when leaving MEM_WAIT
        drive(0, 0, 0, 1, 0);
        tick();
        drive(1, 0, 0, 0, 0);
        chk_ctl("mw_exit_lu", 5'b00010);
        tick();
        chk("mw_exit_state", 32'(ctrl_state), 32'd1);
        drive(0, 0, 0, 0, 0);
        tick();

        // Watchdog: six busy cycles, flag sets on the 4th edge and sticks
        drive(0, 0, 0, 1, 0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("wd_tmo", 32'(mem_timeout), (i >= 4) ? 32'd1 : 32'd0);
            $display("%t wd edge %0d tmo=%b", $time, i, mem_timeout);
        end
        drive(0, 0, 0, 0, 0);
        tick();
        chk("wd_sticky", 32'(mem_timeout), 32'd1);

        // Async reset mid-stall: outputs and state drop without a clock edge
        drive(1, 0, 0, 0, 0);
        tick();
        chk("pre_rst_state", 32'(ctrl_state), 32'd1);
        drive(0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_tmo", 32'(mem_timeout), 32'd0);
        chk("arst_state", 32'(ctrl_state), 32'd0);
        chk("arst_ctl", 32'({pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_hold}), 32'd0);
        chk("arst_stall", 32'(stall_cnt), 32'd0);
        #1 rst_n = 1'b1;
        tick();

        // Saturation on the 2-bit instance: five stalls separated by idle cycles
        for (int i = 1; i <= 5; i++) begin
            drive(1, 0, 0, 0, 0);
            tick();
            drive(0, 0, 0, 0, 0);
            tick();
            chk("sat_stall", 32'(s_stall_cnt), (i >= 3) ? 32'd3 : 32'(i));
            $display("%t sat stall %0d cnt=%0d", $time, i, s_stall_cnt);
        end
        chk("main_stall5", 32'(stall_cnt), 32'd5);
        drive(1, 0, 0, 0, 1);
        chk_ctl("clr_with_stall_ctl", 5'b00010);
        tick();
        chk("sat_clr", 32'(s_stall_cnt), 32'd0);
        chk("main_clr", 32'(stall_cnt), 32'd0);
        drive(0, 0, 0, 0, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
